upsizing: RTL and testbench
===========================

// Module: upsizing
// PURPOSE
//  AXI-Stream width upsizer: packs pairs of W-bit input beats into one 2W-bit output beat.
//  Inverse of the downsizing block, so downsizing -> upsizing is a lossless loopback.
//  Sits on the receive side, where a narrow link feeds a wide datapath.
//  The first beat of a pair lands in the upper half.
//  The in_tlast input allows odd-length packets, which produce a half-filled output beat.
// PARAMETERS
//  W  32  width of the input word; the output word is 2*W bits
// PORTS
//  aclk        in   1      clock; all logic on its rising edge
//  aresetn     in   1      reset, asynchronous, active-low
//  in_tdata    in   W      narrow input data
//  in_tvalid   in   1      input data valid
//  in_tlast    in   1      input beat is the last beat of its packet
//  in_tready   out  1      upsizer can accept an input beat
//  out_tdata   out  2*W    wide output data; {first beat, second beat}
//  out_tkeep   out  2      half-enables: [1] = upper half valid, [0] = lower half valid
//  out_tlast   out  1      output beat closes a packet
//  out_tvalid  out  1      output data valid
//  out_tready  in   1      downstream accepts the output beat
// BEHAVIOUR
//  Reset (aresetn=0, async): state=IDLE, out_tvalid=0, out_tdata=0, out_tkeep=0, out_tlast=0, hold register=0.
//  Release of reset is sampled synchronously.
//  Transfers: in_fire = in_tvalid & in_tready; out_fire = out_tvalid & out_tready (AXI-S rules).
//  States:
//   IDLE  no data held. in_tready=1.
//    in_fire & !in_tlast -> hold <= in_tdata; go HALF.
//    in_fire &  in_tlast -> out <= {in_tdata, W'0}, keep=2'b10, last=1; go FULL.
//   HALF  upper half held. in_tready=1.
//    in_fire -> out <= {hold, in_tdata}, keep=2'b11, last=in_tlast; go FULL.
//   FULL  out_tvalid=1. in_tready = out_tready (combinational, no bubble).
//    out_fire & !in_fire -> IDLE.
//    out_fire & in_fire -> handled as in IDLE (go HALF, or stay FULL with keep 2'b10).
//    !out_tready -> hold everything stable.
//  Output stability: out_tdata/keep/last must not change while out_tvalid=1 and out_tready=0.
//  out_tvalid never drops without an out_fire.
//  Latency: the output is valid the cycle after the second (or tlast) input beat is accepted.
//  Throughput: with out_tready held at 1, one input beat is accepted every cycle and one output beat is produced every 2 cycles.
//  No bubble on the output->input path.
//  Data is never dropped or duplicated.
//  Unused lower half on a keep=2'b10 beat is driven to zero.
//  in_tdata is ignored when in_tvalid=0.
//  in_tvalid may deassert in HALF; the held word waits indefinitely.
//  Reset mid-operation discards any held half-word and any pending output beat.
// TESTING
//  1. After reset, out_tready=1; stream "ABCD","EFGH","IJKL","MNOP" back-to-back
//     -> out "ABCDEFGH", then "IJKLMNOP", keep=2'b11; in_tready held at 1 throughout.
//  2. out_tready=0 for 8 cycles while 6 words are offered
//     -> in_tready drops in FULL, out_tdata stable, no loss; all 3 pairs arrive in order once ready returns.
//  3. Odd packet "ABCD","EFGH","IJKL"(tlast)
//     -> "ABCDEFGH" keep=11 last=0, then {"IJKL",32'h0} keep=10 last=1.
//  4. tlast on the second word of "WXYZ","0123"
//     -> "WXYZ0123" keep=11 last=1.
//  5. aresetn pulsed low while in HALF holding "ABCD"
//     -> out_tvalid=0 immediately; next pair "EFGH","IJKL" yields "EFGHIJKL".
//  6. Loopback downsizing->upsizing with the random out_tready pattern over 50 cycles
//     -> scoreboard of 2W words matches exactly; queues empty at end.

Source files
------------

// File: rtl/upsizing.sv
// AXI-Stream width upsizer: packs pairs of W-bit input beats into one 2W-bit output beat.
// The first beat of a pair lands in the upper half. A tlast on the first beat of a pair
// closes the packet early with a half-filled beat (keep=2'b10, lower half zero).
module upsizing #(
    parameter int unsigned W = 32
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic [W-1:0]   in_tdata,
    input  logic           in_tvalid,
    input  logic           in_tlast,
    output logic           in_tready,
    output logic [2*W-1:0] out_tdata,
    output logic [1:0]     out_tkeep,
    output logic           out_tlast,
    output logic           out_tvalid,
    input  logic           out_tready
);

    typedef enum logic [1:0] {StIdle, StHalf, StFull} state_e;

    state_e           state_q;
    logic [W-1:0]     hold_q;
    logic [2*W-1:0]   data_q;
    logic [1:0]       keep_q;
    logic             last_q;

    logic             in_fire;
    logic             out_fire;

    assign out_tvalid = (state_q == StFull);
    assign out_tdata  = data_q;
    assign out_tkeep  = keep_q;
    assign out_tlast  = last_q;

    assign in_fire  = in_tvalid & in_tready;
    assign out_fire = out_tvalid & out_tready;

    // Input readiness: free while empty or half-full; in FULL it follows the sink so a
    // draining beat and a new input beat can transfer in the same cycle.
    always_comb begin
        in_tready = 1'b0;
        unique case (state_q)
            StIdle:  in_tready = 1'b1;
            StHalf:  in_tready = 1'b1;
            StFull:  in_tready = out_tready;
            default: in_tready = 1'b0;
        endcase
    end

    // Packing state machine with registered output beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            hold_q  <= '0;
            data_q  <= '0;
            keep_q  <= 2'b00;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                // In FULL an input beat can only fire alongside out_fire, so it is
                // treated exactly like a first beat arriving in IDLE.
                StIdle, StFull: begin
                    if (in_fire) begin
                        if (in_tlast) begin
                            data_q  <= {in_tdata, {W{1'b0}}};
                            keep_q  <= 2'b10;
                            last_q  <= 1'b1;
                            state_q <= StFull;
                        end else begin
                            hold_q  <= in_tdata;
                            state_q <= StHalf;
                        end
                    end else if (out_fire) begin
                        state_q <= StIdle;
                    end
                end
                StHalf: begin
                    if (in_fire) begin
                        data_q  <= {hold_q, in_tdata};
                        keep_q  <= 2'b11;
                        last_q  <= in_tlast;
                        state_q <= StFull;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_upsizing.sv
// Self-checking bench for upsizing: directed stimulus with a scoreboard queue of
// expected wide beats, popped by an independent output monitor.
module tb_upsizing;

    localparam int unsigned W = 32;

    logic           aclk;
    logic           aresetn;
    logic [W-1:0]   in_tdata;
    logic           in_tvalid;
    logic           in_tlast;
    logic           in_tready;
    logic [2*W-1:0] out_tdata;
    logic [1:0]     out_tkeep;
    logic           out_tlast;
    logic           out_tvalid;
    logic           out_tready;

    typedef struct {
        logic [2*W-1:0] d;
        logic [1:0]     k;
        logic           l;
    } beat_t;

    beat_t sb[$];

    int n_total;
    int n_pass;
    int stalls;

    logic           stall_prev;
    logic [2*W-1:0] stall_data;
    logic [1:0]     stall_keep;
    logic           stall_last;

    upsizing #(.W(W)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic push_exp(input logic [2*W-1:0] d, input logic [1:0] k, input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        sb.push_back(b);
    endtask

    // Holds one input beat until accepted; called at posedge+1, returns at posedge+1.
    task automatic send(input logic [W-1:0] d, input logic l);
        bit acc;
        int cyc;
        in_tdata  = d;
        in_tlast  = l;
        in_tvalid = 1'b1;
        acc = 1'b0;
        cyc = 0;
        while (!acc) begin
            @(negedge aclk);
            acc = in_tready;
            @(posedge aclk);
            #1;
            if (!acc) stalls++;
            cyc++;
            if (cyc > 200) begin
                n_total++;
                $display("FAIL send_timeout: got no in_tready expected accept of %h", d);
                break;
            end
        end
    endtask

    task automatic idle();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tdata  = 'x;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        repeat (2) @(posedge aclk);
        #1;
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: pops the scoreboard on every out_fire and checks stall stability.
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", 64'(out_tvalid), 64'd1);
                chk("stall_data_stable", out_tdata, stall_data);
                chk("stall_keep_stable", 64'(out_tkeep), 64'(stall_keep));
                chk("stall_last_stable", 64'(out_tlast), 64'(stall_last));
            end
            if (out_tvalid && out_tready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got %h expected no beat", out_tdata);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("out_data", out_tdata, e.d);
                    chk("out_keep", 64'(out_tkeep), 64'(e.k));
                    chk("out_last", 64'(out_tlast), 64'(e.l));
                end
            end
            stall_prev = out_tvalid && !out_tready;
            stall_data = out_tdata;
            stall_keep = out_tkeep;
            stall_last = out_tlast;
        end
    end

    initial begin
        logic [2*W-1:0] wide;
        n_total    = 0;
        n_pass     = 0;
        stalls     = 0;
        stall_prev = 1'b0;
        aresetn    = 1'b0;
        out_tready = 1'b0;
        idle();

        // Reset state
        #12;
        chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_out_tdata", out_tdata, 64'd0);
        chk("rst_out_tkeep", 64'(out_tkeep), 64'd0);
        chk("rst_out_tlast", 64'(out_tlast), 64'd0);
        chk("rst_in_tready", 64'(in_tready), 64'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // 1. Back-to-back stream, no backpressure
        out_tready = 1'b1;
        push_exp({"ABCD", "EFGH"}, 2'b11, 1'b0);
        push_exp({"IJKL", "MNOP"}, 2'b11, 1'b0);
        stalls = 0;
        send("ABCD", 1'b0);
        send("EFGH", 1'b0);
        send("IJKL", 1'b0);
        send("MNOP", 1'b0);
        idle();
        chk("t1_no_stall", 64'(stalls), 64'd0);
        drain("t1_drain");

        // 2. Sink stalled for 8 cycles while 6 words are offered
        out_tready = 1'b0;
        push_exp({"QRST", "UVWX"}, 2'b11, 1'b0);
        push_exp({"YZ01", "2345"}, 2'b11, 1'b0);
        push_exp({"6789", "abcd"}, 2'b11, 1'b0);
        fork
            begin
                send("QRST", 1'b0);
                send("UVWX", 1'b0);
                send("YZ01", 1'b0);
                send("2345", 1'b0);
                send("6789", 1'b0);
                send("abcd", 1'b0);
                idle();
            end
            begin
                repeat (8) @(posedge aclk);
                #1;
                out_tready = 1'b1;
            end
            begin
                repeat (4) @(posedge aclk);
                @(negedge aclk);
                chk("t2_in_tready_low", 64'(in_tready), 64'd0);
                chk("t2_out_tvalid_high", 64'(out_tvalid), 64'd1);
            end
        join
        drain("t2_drain");

        // 3. Odd-length packet
        push_exp({"ABCD", "EFGH"}, 2'b11, 1'b0);
        push_exp({"IJKL", 32'h0}, 2'b10, 1'b1);
        send("ABCD", 1'b0);
        send("EFGH", 1'b0);
        send("IJKL", 1'b1);
        idle();
        drain("t3_drain");

        // 4. tlast on the second word of a pair
        push_exp({"WXYZ", "0123"}, 2'b11, 1'b1);
        send("WXYZ", 1'b0);
        send("0123", 1'b1);
        idle();
        drain("t4_drain");

        // 5. Reset while holding a half word
        send("ABCD", 1'b0);
        idle();
        #2;
        aresetn = 1'b0;
        #1;
        chk("t5_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("t5_in_tready", 64'(in_tready), 64'd1);
        chk("t5_out_tdata", out_tdata, 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        push_exp({"EFGH", "IJKL"}, 2'b11, 1'b1);
        send("EFGH", 1'b0);
        send("IJKL", 1'b1);
        idle();
        drain("t5_drain");

        // 6. Downsizer-style source (upper half first) with random sink readiness
        for (int i = 0; i < 10; i++) begin
            wide[2*W-1:W] = 32'h10203040 + 32'(i) * 32'h01010101;
            wide[W-1:0]   = ~(32'h0a0b0c0d + 32'(i) * 32'h00110011);
            push_exp(wide, 2'b11, (i % 3) == 2);
        end
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    wide[2*W-1:W] = 32'h10203040 + 32'(i) * 32'h01010101;
                    wide[W-1:0]   = ~(32'h0a0b0c0d + 32'(i) * 32'h00110011);
                    send(wide[2*W-1:W], 1'b0);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge aclk);
                        #1;
                    end
                    send(wide[W-1:0], (i % 3) == 2);
                end
                idle();
            end
            begin
                repeat (50) begin
                    @(posedge aclk);
                    #1;
                    out_tready = 1'($urandom_range(0, 1));
                end
                out_tready = 1'b1;
            end
        join
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
